// File: rtl/muldiv_if.sv
// Handshake/data bundle between the execute stage and the multiply/divide sequencer.
// The master side is the pipeline; the slave side is muldiv_seq.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] busB;
    logic             mt_hi;
    logic             mt_lo;
    logic             rd_hilo;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, busA, busB, mt_hi, mt_lo, rd_hilo, flush,
        input  busy, stall, done, div_by_zero, HI, LO
    );

    modport slave (
        input  start, op, busA, busB, mt_hi, mt_lo, rd_hilo, flush,
        output busy, stall, done, div_by_zero, HI, LO
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO pair.
// Optional MULDIV_EARLY_OUT_EN: multiplies stop once the remaining multiplier bits are zero.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave mdu
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_n;

    logic [1:0]         op_r;
    logic               sign_a_r;
    logic               sign_b_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;
    logic               dbz_r;

    logic               load_s;
    logic               iter_s;
    logic               fix_wr_s;
    logic               hi_wr_s;
    logic               lo_wr_s;
    logic               dbz_s;
    logic               last_s;
    logic               cnt_max_s;
    logic [WIDTH-1:0]   a_abs_s;
    logic [WIDTH-1:0]   b_abs_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     trial_s;
    logic               q_bit_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand magnitudes: signed ops work on |x| and fix the sign afterwards.
    always_comb begin
        a_abs_s = mdu.busA;
        b_abs_s = mdu.busB;
        if (mdu.op[0] && mdu.busA[WIDTH-1]) begin
            a_abs_s = neg_w(mdu.busA);
        end else begin
            a_abs_s = mdu.busA;
        end
        if (mdu.op[0] && mdu.busB[WIDTH-1]) begin
            b_abs_s = neg_w(mdu.busB);
        end else begin
            b_abs_s = mdu.busB;
        end
    end

    // Restoring-divide trial: remainder lives in acc_r upper half, dividend/quotient in the lower half.
    assign shifted_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    assign trial_s   = shifted_s - {1'b0, b_r};
    assign q_bit_s   = ~trial_s[WIDTH];
    assign cnt_max_s = (cnt_r == CW'(WIDTH-1));

    // Last CALC iteration detection.
    always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
        if (op_r[1]) begin
            last_s = cnt_max_s;
        end else begin
            last_s = cnt_max_s | (b_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
        end
`else
        last_s = cnt_max_s;
`endif
    end

    // Sign correction applied in FIX; the remainder follows the dividend's sign.
    always_comb begin
        res_hi_s = acc_r[2*WIDTH-1:WIDTH];
        res_lo_s = acc_r[WIDTH-1:0];
        if (op_r[1]) begin
            if (sign_a_r ^ sign_b_r) begin
                res_lo_s = neg_w(acc_r[WIDTH-1:0]);
            end else begin
                res_lo_s = acc_r[WIDTH-1:0];
            end
            if (sign_a_r) begin
                res_hi_s = neg_w(acc_r[2*WIDTH-1:WIDTH]);
            end else begin
                res_hi_s = acc_r[2*WIDTH-1:WIDTH];
            end
        end else begin
            if (sign_a_r ^ sign_b_r) begin
                {res_hi_s, res_lo_s} = neg_2w(acc_r);
            end else begin
                {res_hi_s, res_lo_s} = acc_r;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and datapath strobes; flush overrides everything, start beats MTHI/MTLO.
    always_comb begin
        state_n  = state_r;
        load_s   = 1'b0;
        iter_s   = 1'b0;
        fix_wr_s = 1'b0;
        hi_wr_s  = 1'b0;
        lo_wr_s  = 1'b0;
        dbz_s    = 1'b0;
        if (mdu.flush) begin
            state_n = IDLE;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (mdu.start) begin
                        load_s = 1'b1;
                        if (mdu.op[1] && (mdu.busB == {WIDTH{1'b0}})) begin
                            state_n = DONE;
                            dbz_s   = 1'b1;
                        end else begin
                            state_n = CALC;
                        end
                    end else begin
                        state_n = IDLE;
                        hi_wr_s = mdu.mt_hi;
                        lo_wr_s = mdu.mt_lo;
                    end
                end
                CALC: begin
                    iter_s = 1'b1;
                    if (last_s) begin
                        state_n = FIX;
                    end else begin
                        state_n = CALC;
                    end
                end
                FIX: begin
                    fix_wr_s = 1'b1;
                    state_n  = DONE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Work registers, HI/LO and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= 2'b00;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            b_r      <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            busy_r <= (state_n == CALC) || (state_n == FIX);
            done_r <= (state_n == DONE);
            dbz_r  <= dbz_s;
            if (load_s) begin
                op_r     <= mdu.op;
                sign_a_r <= mdu.op[0] & mdu.busA[WIDTH-1];
                sign_b_r <= mdu.op[0] & mdu.busB[WIDTH-1];
                b_r      <= b_abs_s;
                mcand_r  <= {{WIDTH{1'b0}}, a_abs_s};
                cnt_r    <= {CW{1'b0}};
                if (mdu.op[1]) begin
                    acc_r <= {{WIDTH{1'b0}}, a_abs_s};
                end else begin
                    acc_r <= {(2*WIDTH){1'b0}};
                end
            end else if (iter_s) begin
                cnt_r <= cnt_r + CW'(1);
                if (op_r[1]) begin
                    acc_r <= {(q_bit_s ? trial_s[WIDTH-1:0] : shifted_s[WIDTH-1:0]),
                              acc_r[WIDTH-2:0], q_bit_s};
                end else begin
                    if (b_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end
                    mcand_r <= {mcand_r[2*WIDTH-2:0], 1'b0};
                    b_r     <= {1'b0, b_r[WIDTH-1:1]};
                end
            end
            if (fix_wr_s) begin
                hi_r <= res_hi_s;
                lo_r <= res_lo_s;
            end else begin
                if (hi_wr_s) begin
                    hi_r <= mdu.busA;
                end
                if (lo_wr_s) begin
                    lo_r <= mdu.busA;
                end
            end
        end
    end

    assign mdu.busy        = busy_r;
    assign mdu.done        = done_r;
    assign mdu.div_by_zero = dbz_r;
    assign mdu.HI          = hi_r;
    assign mdu.LO          = lo_r;
    assign mdu.stall       = busy_r & (mdu.start | mdu.rd_hilo | mdu.mt_hi | mdu.mt_lo);

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed bench for muldiv_seq against a plain-arithmetic HI/LO model.
module tb_muldiv_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    muldiv_if #(.WIDTH(32)) mdu ();

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdu   (mdu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result: {HI,LO} after the op, given the previous {HI,LO}.
    function automatic logic [63:0] ref_hilo(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] prev);
        longint sa;
        longint sb;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: return {32'h0, a} * {32'h0, b};
            2'b01: return sa * sb;
            2'b10: begin
                if (b == 32'h0) return prev;
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'h0) return prev;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Number of CALC cycles the operation should spend.
    function automatic int calc_cycles(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] bb;
        int n;
        bb = (op[0] && b[31]) ? (32'h0 - b) : b;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (bb[i]) n = i + 1;
        end
        if (op[1]) return 32;
`ifdef MULDIV_EARLY_OUT_EN
        return (n == 0) ? 1 : n;
`else
        return (n >= 0) ? 32 : 32;
`endif
    endfunction

    // Step cycles until done, checking busy/stall in every cycle before it.
    task automatic wait_done(input int busy_last, input int rd_from, input string tag, output int cyc);
        logic exp_busy;
        cyc = 1;
        while (mdu.done !== 1'b1 && cyc < 200) begin
            if (rd_from > 0 && cyc >= rd_from) mdu.rd_hilo = 1'b1;
            #1;
            exp_busy = (cyc <= busy_last);
            check({tag, "_busy"}, mdu.busy, exp_busy);
            check({tag, "_stall"}, mdu.stall,
                  exp_busy & (mdu.start | mdu.rd_hilo | mdu.mt_hi | mdu.mt_lo));
            tick();
            cyc++;
        end
        if (cyc >= 200) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int rd_from, input bit with_mt, input string tag);
        logic [63:0] exp;
        bit dbz;
        int n;
        int cyc;
        exp = ref_hilo(op, a, b, {hi_m, lo_m});
        dbz = op[1] && (b == 32'h0);
        n = calc_cycles(op, b);
        mdu.op = op;
        mdu.busA = a;
        mdu.busB = b;
        mdu.start = 1'b1;
        mdu.mt_hi = with_mt;
        tick();
        mdu.start = 1'b0;
        mdu.mt_hi = 1'b0;
        mdu.rd_hilo = 1'b0;
        wait_done(dbz ? 0 : n + 1, rd_from, tag, cyc);
        check({tag, "_cycle"}, cyc, dbz ? 1 : n + 2);
        check({tag, "_dbz"}, mdu.div_by_zero, dbz);
        check({tag, "_busy_done"}, mdu.busy, 1'b0);
        check({tag, "_stall_done"}, mdu.stall, 1'b0);
        check({tag, "_hi"}, mdu.HI, exp[63:32]);
        check({tag, "_lo"}, mdu.LO, exp[31:0]);
        {hi_m, lo_m} = exp;
        mdu.rd_hilo = 1'b0;
        tick();
    endtask

    task automatic mt_write(input bit sel_hi, input logic [31:0] val);
        mdu.mt_hi = sel_hi;
        mdu.mt_lo = !sel_hi;
        mdu.busA = val;
        tick();
        mdu.mt_hi = 1'b0;
        mdu.mt_lo = 1'b0;
        if (sel_hi) hi_m = val; else lo_m = val;
        check("mt_hi_val", mdu.HI, hi_m);
        check("mt_lo_val", mdu.LO, lo_m);
    endtask

    initial begin
        int cyc;
        bit seen_done;
        logic [31:0] a;
        logic [31:0] b;
        checks = 0;
        failures = 0;
        hi_m = 32'h0;
        lo_m = 32'h0;
        mdu.start = 1'b0;
        mdu.op = 2'b00;
        mdu.busA = 32'h0;
        mdu.busB = 32'h0;
        mdu.mt_hi = 1'b0;
        mdu.mt_lo = 1'b0;
        mdu.rd_hilo = 1'b0;
        mdu.flush = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        mdu.start = 1'b1;
        #1;
        check("rst_busy", mdu.busy, 1'b0);
        check("rst_stall", mdu.stall, 1'b0);
        check("rst_done", mdu.done, 1'b0);
        check("rst_dbz", mdu.div_by_zero, 1'b0);
        check("rst_hilo", {mdu.HI, mdu.LO}, 64'h0);
        mdu.start = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, "multu_max");
        run_op(2'b01, 32'hFFFFFFFD, 32'd5, 0, 1'b0, "mult_neg");
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0, 1'b0, "div_neg");
        mt_write(1'b1, 32'h11);
        mt_write(1'b0, 32'h22);
        run_op(2'b10, 32'd100, 32'd0, 0, 1'b0, "divu_zero");
        run_op(2'b10, 32'd100, 32'd0, 0, 1'b1, "start_beats_mt");
        run_op(2'b00, 32'd6, 32'd7, 2, 1'b0, "multu_rd_stall");
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, "div_ovf");
        run_op(2'b00, 32'd7, 32'd3, 0, 1'b0, "multu_7x3");
        run_op(2'b00, 32'd9, 32'd0, 0, 1'b0, "multu_9x0");

        // Second start held through busy is only taken once DONE is reached.
        mdu.op = 2'b00;
        mdu.busA = 32'd3;
        mdu.busB = 32'd5;
        mdu.start = 1'b1;
        tick();
        mdu.op = 2'b10;
        mdu.busA = 32'd1000;
        mdu.busB = 32'd7;
        wait_done(calc_cycles(2'b00, 32'd5) + 1, 0, "chain1", cyc);
        check("chain1_cycle", cyc, calc_cycles(2'b00, 32'd5) + 2);
        check("chain1_lo", mdu.LO, 32'd15);
        check("chain1_hi", mdu.HI, 32'd0);
        tick();
        mdu.start = 1'b0;
        wait_done(33, 0, "chain2", cyc);
        check("chain2_cycle", cyc, 34);
        check("chain2_hilo", {mdu.HI, mdu.LO}, {32'd6, 32'd142});
        hi_m = 32'd6;
        lo_m = 32'd142;
        tick();

        // Flush in cycle 10 of a divide: back to IDLE, HI/LO untouched, no done.
        mdu.op = 2'b11;
        mdu.busA = 32'hFFFFFC18;
        mdu.busB = 32'd7;
        mdu.start = 1'b1;
        tick();
        mdu.start = 1'b0;
        repeat (9) tick();
        mdu.flush = 1'b1;
        tick();
        mdu.flush = 1'b0;
        check("flush_busy", mdu.busy, 1'b0);
        check("flush_done", mdu.done, 1'b0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mdu.done === 1'b1 || mdu.busy === 1'b1) seen_done = 1'b1;
            tick();
        end
        check("flush_quiet", seen_done, 1'b0);
        check("flush_hilo", {mdu.HI, mdu.LO}, {hi_m, lo_m});

        for (int k = 0; k < 24; k++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 255);
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1, 2, 3: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_op(2'($urandom_range(0, 3)), a, b, ($urandom_range(0, 1) == 1) ? 2 : 0, 1'b0, "rand");
        end

        // Asynchronous reset in the middle of CALC clears everything at once.
        mdu.op = 2'b00;
        mdu.busA = 32'h12345678;
        mdu.busB = 32'h9ABCDEF1;
        mdu.start = 1'b1;
        tick();
        mdu.start = 1'b0;
        repeat (5) tick();
        mdu.start = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", mdu.busy, 1'b0);
        check("midrst_stall", mdu.stall, 1'b0);
        check("midrst_done", mdu.done, 1'b0);
        check("midrst_hilo", {mdu.HI, mdu.LO}, 64'h0);
        mdu.start = 1'b0;
        tick();
        rst_n = 1'b1;
        hi_m = 32'h0;
        lo_m = 32'h0;
        tick();
        run_op(2'b01, 32'h80000000, 32'h80000000, 0, 1'b0, "post_rst_mult");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer beside the execute stage of the pipelined CPU.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs one bit per cycle, holding the 64-bit result in architectural HI/LO.
- Raises a stall to the pipeline while a later instruction needs HI/LO, or while it would start another operation, before the current one finishes.
- Also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; iteration count of CALC.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  EX holds a mult/div instruction
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- busA  in  WIDTH  rs operand (multiplicand/dividend); data for mt_hi/mt_lo
- busB  in  WIDTH  rt operand (multiplier/divisor)
- mt_hi  in  1  MTHI in EX
- mt_lo  in  1  MTLO in EX
- rd_hilo  in  1  MFHI/MFLO in EX
- flush  in  1  abort the in-flight operation (branch/exception squash)
- busy  out  1  operation in progress
- stall  out  1  freeze IF/ID/EX this cycle
- done  out  1  one-cycle pulse; HI/LO newly valid
- div_by_zero  out  1  one-cycle pulse with done when the divisor is 0
- HI  out  WIDTH  HI register
- LO  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE; HI=LO=0; busy=stall=done=div_by_zero=0; counters and work registers cleared.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE, start=1:
  - Latch op.
  - For signed ops, latch |busA| and |busB| plus both sign bits; for unsigned ops, latch the raw operands.
  - If the op is divide and busB=0, go to DONE with div_by_zero=1; HI/LO stay unchanged.
  - Otherwise go to CALC with counter=0.
- CALC: one iteration per cycle, counter increments; go to FIX when counter=WIDTH-1.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; the quotient bit is set when the trial remainder is >=0.
- FIX (1 cycle): sign correction; at the edge leaving FIX, write HI/LO and go to DONE.
  - MULT: negate the 64-bit product if the signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Result mapping: multiply {HI,LO}=product; divide LO=quotient, HI=remainder.
- DONE (1 cycle): done=1, busy=0; return to IDLE. A start in DONE is accepted as in IDLE.
- Latency: with start sampled at edge 0, busy is high in cycles 1..WIDTH+1 and done is in cycle WIDTH+2 (34 for WIDTH=32). Divide-by-zero: done in cycle 1.
- Overflow case: DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.
- stall = busy & (start | rd_hilo | mt_hi | mt_lo), combinational.
  - While busy, start is ignored; the stall holds the instruction upstream.
  - stall is 0 in DONE and in IDLE.
- mt_hi/mt_lo:
  - In IDLE or DONE, write busA to HI/LO at the clock edge.
  - If start and mt_* are both asserted, start wins and the write is dropped.
- flush:
  - At the next edge, go to IDLE from any state; HI/LO unchanged; no done pulse.
  - flush has priority over start and over the FIX write.
  - flush in DONE still leaves the already-written HI/LO intact.
- All outputs except stall are registered.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: a multiply leaves CALC after the iteration in which the remaining shifted multiplier bits become 0 (minimum 1 CALC cycle). busy and the done timing shorten accordingly. Divide is unaffected.
- Undefined: every multiply takes exactly WIDTH CALC cycles.

Test Plan:
- MULTU busA=0xFFFFFFFF busB=0xFFFFFFFF -> done in cycle 34, HI=0xFFFFFFFE, LO=0x00000001, busy high cycles 1..33 (macro off).
- MULT busA=0xFFFFFFFD (-3) busB=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV busA=0xFFFFFFF9 (-7) busB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU busA=100 busB=0 with HI/LO preloaded via MTHI/MTLO 0x11/0x22 -> cycle 1: done=1, div_by_zero=1; HI=0x11, LO=0x22 unchanged.
- MULTU 6*7, rd_hilo=1 from cycle 2 -> stall=1 cycles 2..33, 0 in cycle 34; LO=42, HI=0. A second start held during busy is ignored until DONE.
- DIV in flight, flush=1 in cycle 10 -> IDLE in cycle 11, busy=0, no done pulse, HI/LO keep prior values. Assert rst_n=0 mid-CALC -> all outputs 0 immediately.
- MULTU 7*3 with MULDIV_EARLY_OUT_EN -> CALC cycles 1-2, FIX 3, done in cycle 4, LO=21. MULTU 9*0 -> done in cycle 3, LO=0.
